divider_pipe: RTL and testbench
===============================

# divider_pipe

Fully pipelined, parameterised unsigned restoring divider: an unsigned DW-bit dividend divided by a VW-bit divisor, with one quotient bit resolved per stage. It accepts a new operand pair every cycle, carries a sideband tag and a divide-by-zero flag alongside each result, and supports downstream backpressure with a valid/ready handshake. It replaces the fixed-constant reciprocal divider in the arithmetic datapath: the dividend is a runtime input and all widths are generic.

## Interface
- DW, default 8: dividend and quotient width, and pipeline depth (stages); must be ≥ 2.
- VW, default 4: divisor and remainder width; must satisfy 1 ≤ VW ≤ DW.
- TAG_W, default 4: sideband tag width, passed through unmodified.
- clk  in  1: clock, rising edge.
- rstn  in  1: reset, asynchronous, active-low.
- in_valid  in  1: operand pair present.
- in_ready  out  1: pipeline can accept this cycle.
- dividend  in  DW: unsigned dividend.
- divisor  in  VW: unsigned divisor.
- in_tag  in  TAG_W: sideband.
- out_valid  out  1: result present.
- out_ready  in  1: consumer accepts result.
- quotient  out  DW: unsigned quotient.
- remainder  out  VW: unsigned remainder.
- dbz  out  1: divisor was zero.
- out_tag  out  TAG_W: in_tag of the same transaction.

## Operation
- Pipeline structure:
  - The pipeline has stages S0..S(DW-1).
  - Each stage holds: valid, partial remainder (VW bits), divisor, the remaining dividend bits, quotient bits so far, dbz, and tag.
  - Outputs are driven directly from S(DW-1) registers; there is no output combinational logic beyond wiring.
- Stage k, for k = 0..DW-1, resolves quotient bit DW-1-k:
  - Trial value t = {rem_prev, dividend[DW-1-k]}, VW+1 bits; rem_prev = 0 for S0.
  - If t ≥ {1'b0, divisor}: q bit = 1 and rem = (t − divisor)[VW-1:0].
  - Otherwise: q bit = 0 and rem = t[VW-1:0].
  - All comparisons are unsigned.
- Divisor = 0:
  - No special datapath; the algorithm's natural result stands.
  - Every trial succeeds, so quotient = all ones and remainder = dividend[VW-1:0].
  - dbz = 1 is captured in S0 and carried with the transaction.
- Handshake:
  - Global advance: adv = out_ready | ~out_valid.
  - in_ready = adv, combinational.
  - A transaction is accepted on a rising edge where in_valid & in_ready.
  - When adv = 1, every stage loads from its predecessor, and S0 loads the new operands with valid = in_valid.
  - When adv = 0, all stages hold their values.
  - A result is consumed on an edge where out_valid & out_ready.
- Bubbles (invalid stages) advance like data. They are not collapsed, except that an invalid S(DW-1) never stalls the pipeline.
- Ordering is strict FIFO; tag, dbz, quotient and remainder of one transaction always appear together.

## Timing
- Reset (rstn low, asynchronous):
  - All stage valids = 0 and all data registers = 0.
  - Outputs: out_valid = 0, quotient = 0, remainder = 0, dbz = 0, out_tag = 0.
  - in_ready = 1 immediately after reset.
- Reset asserted mid-operation discards all in-flight transactions; no partial result emerges after deassertion.
- Latency: a transaction accepted on edge E is presented on the outputs right after edge E+DW-1 when there are no stalls (DW = 8: accept edge 0, output after edge 7).
- Each stall cycle (out_valid = 1, out_ready = 0) adds exactly one cycle to every in-flight transaction.
- Throughput: one result per cycle with in_valid and out_ready held high.
- Output stability: while out_valid = 1 and out_ready = 0, all outputs stay stable; in_ready = 0, so no new acceptance can occur.
- Simultaneous events: consumption of the last-stage result and acceptance of a new input in the same cycle is legal and loses nothing.
- out_ready may be high while out_valid = 0; this has no effect.

## Test plan
All scenarios use DW = 8, VW = 4, TAG_W = 4.
- Reset, then a single op 200/7 with tag 3 at edge 0, out_ready = 1:
  - Response: quotient = 28, remainder = 4, dbz = 0, out_tag = 3.
  - out_valid high for exactly one cycle, appearing after edge 7.
- Boundary values 255/15, 255/1, 5/9, 0/3:
  - Response: (17, 0), (255, 0), (0, 5), (0, 0); dbz = 0 for all.
- Divide by zero, 13/0 with tag 9:
  - Response: quotient = 255, remainder = 13, dbz = 1, out_tag = 9.
  - The next op 14/2 yields 7 r0 with dbz = 0.
- Streaming: 32 back-to-back random ops, out_ready = 1.
  - Response: 32 consecutive results in order, each matching the reference model, with out_valid continuously high from edge 7 through edge 38.
- Backpressure: stream ops while out_ready is driven by a random 50% pattern.
  - Response: no loss, no duplication, order preserved.
  - Outputs are held stable across every stall cycle, and in_ready = 0 exactly when out_valid & ~out_ready.
- Reset mid-operation: assert rstn low for 2 cycles with 5 ops in flight, then release.
  - Response: out_valid = 0 and outputs = 0 during reset and until a new op is accepted.
  - The first post-reset op 100/10 yields 10 r0 with its own tag.

Source files
------------

// File: rtl/divider_pipe_if.sv
// rtl/divider_pipe_if.sv - operand/result handshake bundle for the pipelined divider
interface divider_pipe_if #(
  parameter int DW    = 8,
  parameter int VW    = 4,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    dividend;
  logic [VW-1:0]    divisor;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    quotient;
  logic [VW-1:0]    remainder;
  logic             dbz;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, dividend, divisor, in_tag, out_ready,
    input  in_ready, out_valid, quotient, remainder, dbz, out_tag
  );

  modport slave (
    input  in_valid, dividend, divisor, in_tag, out_ready,
    output in_ready, out_valid, quotient, remainder, dbz, out_tag
  );
endinterface

// File: rtl/divider_pipe.sv
// rtl/divider_pipe.sv - fully pipelined unsigned restoring divider, one quotient bit per stage
module divider_pipe #(
  parameter int DW    = 8,
  parameter int VW    = 4,
  parameter int TAG_W = 4
) (
  input  logic            clk,
  input  logic            rstn,
  divider_pipe_if.slave   bus
);

  logic adv;

  // Returns {quotient bit, new partial remainder} for one restoring step.
  function automatic logic [VW:0] step(input logic [VW-1:0] r, input logic b,
                                       input logic [VW-1:0] d);
    logic [VW:0] t;
    logic [VW:0] diff;
    t    = {r, b};
    diff = t - {1'b0, d};
    if (t >= {1'b0, d}) step = {1'b1, diff[VW-1:0]};
    else                step = {1'b0, t[VW-1:0]};
  endfunction

  // Stage k keeps k+1 quotient bits and DW-1-k unconsumed dividend bits.
  for (genvar k = 0; k < DW; k++) begin : g_stage
    logic             vld_p;
    logic             dbz_p;
    logic [VW-1:0]    rem_p;
    logic [VW-1:0]    dvs_p;
    logic [DW-1-k:0]  dvd_p;
    logic [TAG_W-1:0] tag_p;
    logic [VW:0]      res;
    logic [k:0]       quo_nx;

    logic             vld_q;
    logic             dbz_q;
    logic [VW-1:0]    rem_q;
    logic [k:0]       quo_q;
    logic [TAG_W-1:0] tag_q;

    if (k == 0) begin : g_head
      assign vld_p  = bus.in_valid;
      assign dbz_p  = (bus.divisor == '0);
      assign rem_p  = '0;
      assign dvs_p  = bus.divisor;
      assign dvd_p  = bus.dividend;
      assign tag_p  = bus.in_tag;
      assign quo_nx = res[VW];
    end else begin : g_body
      assign vld_p  = g_stage[k-1].vld_q;
      assign dbz_p  = g_stage[k-1].dbz_q;
      assign rem_p  = g_stage[k-1].rem_q;
      assign dvs_p  = g_stage[k-1].g_fwd.dvs_q;
      assign dvd_p  = g_stage[k-1].g_fwd.dvd_q;
      assign tag_p  = g_stage[k-1].tag_q;
      assign quo_nx = {g_stage[k-1].quo_q, res[VW]};
    end

    assign res = step(rem_p, dvd_p[DW-1-k], dvs_p);

    // Bubbles carry zeros so an idle output never shows stale data.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        vld_q <= 1'b0;
        dbz_q <= 1'b0;
        rem_q <= '0;
        quo_q <= '0;
        tag_q <= '0;
      end else if (adv) begin
        vld_q <= vld_p;
        dbz_q <= vld_p & dbz_p;
        rem_q <= vld_p ? res[VW-1:0] : '0;
        quo_q <= vld_p ? quo_nx : '0;
        tag_q <= vld_p ? tag_p : '0;
      end
    end

    if (k < DW-1) begin : g_fwd
      logic [VW-1:0]   dvs_q;
      logic [DW-2-k:0] dvd_q;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          dvs_q <= '0;
          dvd_q <= '0;
        end else if (adv) begin
          dvs_q <= vld_p ? dvs_p : '0;
          dvd_q <= vld_p ? dvd_p[DW-2-k:0] : '0;
        end
      end
    end
  end

  assign adv           = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready  = adv;
  assign bus.out_valid = g_stage[DW-1].vld_q;
  assign bus.quotient  = g_stage[DW-1].quo_q;
  assign bus.remainder = g_stage[DW-1].rem_q;
  assign bus.dbz       = g_stage[DW-1].dbz_q;
  assign bus.out_tag   = g_stage[DW-1].tag_q;

endmodule

// File: tb/tb_divider_pipe.sv
// tb/tb_divider_pipe.sv - directed and streaming checks for divider_pipe
module tb_divider_pipe;
  localparam int DW = 8;
  localparam int VW = 4;
  localparam int TW = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  divider_pipe_if #(.DW(DW), .VW(VW), .TAG_W(TW)) bus ();

  divider_pipe #(.DW(DW), .VW(VW), .TAG_W(TW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] obs_pack();
    return {bus.quotient, bus.remainder, bus.dbz, bus.out_tag};
  endfunction

  // Reference result: plain integer division, all-ones quotient on zero divisor.
  function automatic logic [16:0] model(input logic [7:0] a, input logic [3:0] b,
                                        input logic [3:0] t);
    if (b == 4'd0) return {8'hFF, a[3:0], 1'b1, t};
    return {8'(a / b), 4'(a % b), 1'b0, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic one_op(input logic [7:0] a, input logic [3:0] b, input logic [3:0] t,
                        input logic [7:0] q, input logic [3:0] r, input logic d,
                        input string nm);
    int w = 0;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.in_tag    = t;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk({nm, "_in_ready"}, bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    while (!bus.out_valid && w < 20) begin
      tick();
      w++;
    end
    chk({nm, "_valid"},     bus.out_valid, 1);
    chk({nm, "_latency"},   w, DW - 1);
    chk({nm, "_quotient"},  bus.quotient, q);
    chk({nm, "_remainder"}, bus.remainder, r);
    chk({nm, "_dbz"},       bus.dbz, d);
    chk({nm, "_tag"},       bus.out_tag, t);
    tick();
    chk({nm, "_one_cycle"}, bus.out_valid, 0);
  endtask

  task automatic run_stream(input int n, input bit bp, input string nm,
                            output int first_e, output int last_e);
    logic [16:0] expq[$];
    logic [16:0] held = '0;
    bit hold   = 1'b0;
    bit pend   = 1'b0;
    int issued = 0;
    int got    = 0;
    int e      = 0;
    first_e = -1;
    last_e  = -1;
    while (got < n && e < n * 8 + 64) begin
      if (!pend && issued < n) begin
        bus.dividend = 8'($urandom);
        bus.divisor  = 4'($urandom);
        bus.in_tag   = 4'($urandom);
        pend = 1'b1;
      end
      bus.in_valid  = pend;
      bus.out_ready = bp ? 1'($urandom % 2) : 1'b1;
      #1;
      chk({nm, "_in_ready"}, bus.in_ready, !(bus.out_valid && !bus.out_ready));
      if (bus.out_valid && bus.out_ready) begin
        chk({nm, "_expected"}, expq.size() > 0, 1);
        if (expq.size() > 0) chk({nm, "_result"}, obs_pack(), expq.pop_front());
        got++;
        if (first_e < 0) first_e = e;
        last_e = e;
      end
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(model(bus.dividend, bus.divisor, bus.in_tag));
        issued++;
        pend = 1'b0;
      end
      hold = bus.out_valid && !bus.out_ready;
      if (hold) held = obs_pack();
      tick();
      e++;
      if (hold) begin
        chk({nm, "_stall_valid"}, bus.out_valid, 1);
        chk({nm, "_stall_hold"},  obs_pack(), held);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk({nm, "_count"}, got, n);
    chk({nm, "_leftover"}, expq.size(), 0);
  endtask

  initial begin
    int fe;
    int le;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    tick();
    tick();
    chk("reset_valid",   bus.out_valid, 0);
    chk("reset_outputs", obs_pack(), 0);
    rstn = 1'b1;
    tick();
    chk("reset_in_ready", bus.in_ready, 1);

    one_op(8'd200, 4'd7,  4'd3, 8'd28,  4'd4,  1'b0, "op_200_7");
    one_op(8'd255, 4'd15, 4'd1, 8'd17,  4'd0,  1'b0, "op_255_15");
    one_op(8'd255, 4'd1,  4'd2, 8'd255, 4'd0,  1'b0, "op_255_1");
    one_op(8'd5,   4'd9,  4'd4, 8'd0,   4'd5,  1'b0, "op_5_9");
    one_op(8'd0,   4'd3,  4'd5, 8'd0,   4'd0,  1'b0, "op_0_3");
    one_op(8'd13,  4'd0,  4'd9, 8'd255, 4'd13, 1'b1, "op_13_0");
    one_op(8'd14,  4'd2,  4'd7, 8'd7,   4'd0,  1'b0, "op_14_2");

    run_stream(32, 1'b0, "stream", fe, le);
    chk("stream_first_edge", fe, 8);
    chk("stream_last_edge",  le, 39);
    tick();
    tick();

    run_stream(40, 1'b1, "bp", fe, le);
    repeat (12) tick();
    chk("bp_drained", bus.out_valid, 0);

    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.dividend = 8'(50 + i);
      bus.divisor  = 4'(3 + i);
      bus.in_tag   = 4'(i + 1);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.in_tag   = '0;
    rstn = 1'b0;
    #1;
    chk("midrst_async_valid", bus.out_valid, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("midrst_valid",    bus.out_valid, 0);
      chk("midrst_outputs",  obs_pack(), 0);
      chk("midrst_in_ready", bus.in_ready, 1);
    end
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("postrst_valid",   bus.out_valid, 0);
      chk("postrst_outputs", obs_pack(), 0);
    end
    one_op(8'd100, 4'd10, 4'd6, 8'd10, 4'd0, 1'b0, "op_100_10");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
